// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and constants for the UART transmitter
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } tx_state_e;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    function automatic logic parity_bit(input logic data_xor, input int mode);
        return (mode == PAR_ODD) ? ~data_xor : data_xor;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock show-ahead FIFO holding words awaiting transmission
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic [AW:0]      count_d;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_comb begin
        count_d = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Storage is not reset; only pointers and occupancy define content.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_d;
        end
    end

    assign rdata = mem_q[rd_ptr_q];
    assign full  = (count_q == (AW+1)'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;

endmodule

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - buffered UART transmitter with configurable frame format
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUDRATE   = 57600,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [DATA_BITS-1:0]          tx_data,
    input  logic                          tx_valid,
    output logic                          tx_ready,
    output logic                          tx_out,
    output logic                          busy,
    output logic                          frame_done,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int DIV = CLK_FREQ / BAUDRATE;
    localparam int CW  = $clog2(DIV);

    tx_state_e              state_q, state_d;
    logic [CW-1:0]          baud_q, baud_d;
    logic [3:0]             bit_q, bit_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic                   par_q, par_d;
    logic                   tx_out_q, tx_out_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   rdy_en_q;

    logic                   fifo_full;
    logic                   fifo_empty;
    logic                   fifo_pop;
    logic [DATA_BITS-1:0]   fifo_rdata;
    logic                   bit_end;
    logic                   last_data;
    logic                   last_stop;
    logic                   load;

    sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (tx_valid && tx_ready),
        .pop   (fifo_pop),
        .wdata (tx_data),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign bit_end   = (baud_q == CW'(DIV - 1));
    assign last_data = (bit_q == 4'(DATA_BITS - 1));
    assign last_stop = (bit_q == 4'(STOP_BITS - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            baud_q   <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            par_q    <= 1'b0;
            tx_out_q <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            rdy_en_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            par_q    <= par_d;
            tx_out_q <= tx_out_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            rdy_en_q <= 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (!fifo_empty) state_d = ST_START;
            ST_START:  if (bit_end) state_d = ST_DATA;
            ST_DATA:   if (bit_end && last_data)
                           state_d = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
            ST_PARITY: if (bit_end) state_d = ST_STOP;
            ST_STOP:   if (bit_end && last_stop)
                           state_d = fifo_empty ? ST_IDLE : ST_START;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Line outputs are registered from the current state, so they trail it by one cycle.
    always_comb begin
        load = ((state_q == ST_IDLE) && !fifo_empty) ||
               ((state_q == ST_STOP) && bit_end && last_stop && !fifo_empty);
        fifo_pop = load;

        baud_d = '0;
        if ((state_q != ST_IDLE) && !bit_end) begin
            baud_d = baud_q + 1'b1;
        end

        bit_d = bit_q;
        if (bit_end) begin
            bit_d = (((state_q == ST_DATA) && !last_data) ||
                     ((state_q == ST_STOP) && !last_stop)) ? bit_q + 1'b1 : '0;
        end

        shift_d = shift_q;
        par_d   = par_q;
        if (load) begin
            shift_d = fifo_rdata;
            par_d   = parity_bit(^fifo_rdata, PARITY);
        end else if ((state_q == ST_DATA) && bit_end) begin
            shift_d = shift_q >> 1;
        end

        case (state_q)
            ST_START:  tx_out_d = 1'b0;
            ST_DATA:   tx_out_d = shift_q[0];
            ST_PARITY: tx_out_d = par_q;
            default:   tx_out_d = 1'b1;
        endcase

        busy_d = (state_q != ST_IDLE);
        done_d = (state_q == ST_STOP) && bit_end && last_stop;
    end

    assign tx_ready   = rdy_en_q && !fifo_full;
    assign tx_out     = tx_out_q;
    assign busy       = busy_q;
    assign frame_done = done_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - directed self-checking bench for uart_tx_fifo
module tb_uart_tx_fifo;

    logic       clk   = 1'b0;
    logic       reset = 1'b1;
    logic [8:0] dat   = '0;
    logic [3:0] vld   = '0;
    logic [3:0] rdy, txo, bsy, dn;
    logic [2:0] cnt_a;
    logic [3:0] cnt_e, cnt_o, cnt_s;

    int checks = 0;
    int errors = 0;

    logic [8:0]  wq [0:7];
    logic [10:0] fr [0:7];
    logic        smp_line [0:1023];
    logic        smp_busy [0:1023];
    logic        smp_done [0:1023];
    logic        smp_rdy  [0:1023];
    logic [3:0]  smp_cnt  [0:1023];

    always #5 clk = ~clk;

    uart_tx_fifo #(.CLK_FREQ(16), .BAUDRATE(1), .DATA_BITS(8), .PARITY(0),
                   .STOP_BITS(1), .FIFO_DEPTH(4)) u_a (
        .clk(clk), .reset(reset), .tx_data(dat[7:0]), .tx_valid(vld[0]),
        .tx_ready(rdy[0]), .tx_out(txo[0]), .busy(bsy[0]),
        .frame_done(dn[0]), .fifo_count(cnt_a));

    uart_tx_fifo #(.CLK_FREQ(16), .BAUDRATE(1), .DATA_BITS(8), .PARITY(2),
                   .STOP_BITS(1), .FIFO_DEPTH(8)) u_e (
        .clk(clk), .reset(reset), .tx_data(dat[7:0]), .tx_valid(vld[1]),
        .tx_ready(rdy[1]), .tx_out(txo[1]), .busy(bsy[1]),
        .frame_done(dn[1]), .fifo_count(cnt_e));

    uart_tx_fifo #(.CLK_FREQ(16), .BAUDRATE(1), .DATA_BITS(8), .PARITY(1),
                   .STOP_BITS(1), .FIFO_DEPTH(8)) u_o (
        .clk(clk), .reset(reset), .tx_data(dat[7:0]), .tx_valid(vld[2]),
        .tx_ready(rdy[2]), .tx_out(txo[2]), .busy(bsy[2]),
        .frame_done(dn[2]), .fifo_count(cnt_o));

    uart_tx_fifo #(.CLK_FREQ(16), .BAUDRATE(1), .DATA_BITS(7), .PARITY(0),
                   .STOP_BITS(2), .FIFO_DEPTH(8)) u_s (
        .clk(clk), .reset(reset), .tx_data(dat[6:0]), .tx_valid(vld[3]),
        .tx_ready(rdy[3]), .tx_out(txo[3]), .busy(bsy[3]),
        .frame_done(dn[3]), .fifo_count(cnt_s));

    function automatic logic [3:0] cnt_of(input int i);
        case (i)
            0:       return {1'b0, cnt_a};
            1:       return cnt_e;
            2:       return cnt_o;
            default: return cnt_s;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Offers wq[] to one instance, advancing only on handshake; sample k is taken after edge k.
    task automatic run(input int inst, input int nw, input int n);
        int   idx = 0;
        logic acc;
        for (int k = 0; k < n; k++) begin
            vld[inst] = (idx < nw);
            dat       = (idx < 8) ? wq[idx] : '0;
            acc       = vld[inst] && rdy[inst];
            @(posedge clk);
            #1;
            if (acc) idx++;
            smp_line[k] = txo[inst];
            smp_busy[k] = bsy[inst];
            smp_done[k] = dn[inst];
            smp_rdy[k]  = rdy[inst];
            smp_cnt[k]  = cnt_of(inst);
        end
        vld = '0;
    endtask

    // Expects nf back-to-back frames of fb bits from fr[], first start bit at sample 2.
    task automatic check_stream(input string tag, input int nf, input int fb,
                                input int n, input int exp_busy);
        int   bad_line = 0, bad_busy = 0, bad_done = 0, n_busy = 0, n_done = 0;
        int   rel, per;
        logic el, eb, ed;
        per = fb * 16;
        for (int k = 0; k < n; k++) begin
            rel = k - 2;
            if (rel >= 0 && rel < nf * per) begin
                el = fr[rel / per][(rel % per) / 16];
                eb = 1'b1;
                ed = ((rel % per) == per - 1);
            end else begin
                el = 1'b1;
                eb = 1'b0;
                ed = 1'b0;
            end
            if (smp_line[k] !== el) bad_line++;
            if (smp_busy[k] !== eb) bad_busy++;
            if (smp_done[k] !== ed) bad_done++;
            if (smp_busy[k] === 1'b1) n_busy++;
            if (smp_done[k] === 1'b1) n_done++;
        end
        chk({tag, "_line_bad_cycles"}, bad_line, 0);
        chk({tag, "_busy_bad_cycles"}, bad_busy, 0);
        chk({tag, "_done_bad_cycles"}, bad_done, 0);
        chk({tag, "_busy_cycles"}, n_busy, exp_busy);
        chk({tag, "_done_pulses"}, n_done, nf);
    endtask

    initial begin
        int n_done;
        for (int i = 0; i < 8; i++) begin
            wq[i] = '0;
            fr[i] = '0;
        end

        repeat (3) @(posedge clk);
        #1;
        chk("rst_tx_out", txo, 4'hF);
        chk("rst_busy", bsy, 4'h0);
        chk("rst_frame_done", dn, 4'h0);
        chk("rst_tx_ready", rdy, 4'h0);
        chk("rst_fifo_count", {cnt_a, cnt_e, cnt_o, cnt_s}, 0);
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("ready_after_reset", rdy, 4'hF);

        // 8N1, 0xA5: line 0,1,0,1,0,0,1,0,1,1
        wq[0] = 9'h0A5;
        fr[0] = 11'b0_1101001010;
        run(0, 1, 170);
        chk("lat_sample1_high", smp_line[1], 1'b1);
        chk("lat_sample2_low", smp_line[2], 1'b0);
        check_stream("8n1_a5", 1, 10, 170, 160);

        // 8E1 and 8O1, 0x07 (three ones)
        wq[0] = 9'h007;
        fr[0] = 11'b1_1_00000111_0;
        run(1, 1, 190);
        chk("even_parity_bit", smp_line[154], 1'b1);
        check_stream("8e1_07", 1, 11, 190, 176);

        fr[0] = 11'b1_0_00000111_0;
        run(2, 1, 190);
        chk("odd_parity_bit", smp_line[154], 1'b0);
        check_stream("8o1_07", 1, 11, 190, 176);

        // 7N2, three words written on consecutive edges
        wq[0] = 9'h041; wq[1] = 9'h01C; wq[2] = 9'h063;
        fr[0] = 11'b0_11_1000001_0;
        fr[1] = 11'b0_11_0011100_0;
        fr[2] = 11'b0_11_1100011_0;
        run(3, 3, 490);
        chk("7n2_count_after_writes", smp_cnt[2], 4'd2);
        chk("7n2_second_start", smp_line[162], 1'b0);
        chk("7n2_third_start", smp_line[322], 1'b0);
        check_stream("7n2_burst", 3, 10, 490, 480);

        // Depth 4: valid held high while the engine is busy
        wq[0] = 9'h011; wq[1] = 9'h022; wq[2] = 9'h033;
        wq[3] = 9'h044; wq[4] = 9'h055; wq[5] = 9'h066;
        for (int i = 0; i < 6; i++) fr[i] = {2'b01, wq[i][7:0], 1'b0};
        run(0, 6, 967);
        chk("full_ready_k4", smp_rdy[4], 1'b0);
        chk("full_count_k4", smp_cnt[4], 4'd4);
        chk("full_ready_k100", smp_rdy[100], 1'b0);
        chk("full_count_k100", smp_cnt[100], 4'd4);
        chk("pop_ready_k161", smp_rdy[161], 1'b1);
        chk("pop_count_k161", smp_cnt[161], 4'd3);
        chk("refill_count_k162", smp_cnt[162], 4'd4);
        chk("drained_count", smp_cnt[966], 4'd0);
        check_stream("depth4", 6, 10, 967, 960);

        // Reset during data bit 3 with two words queued
        wq[0] = 9'h000; wq[1] = 9'h05A; wq[2] = 9'h03C;
        run(0, 3, 70);
        chk("abort_pre_line", smp_line[69], 1'b0);
        chk("abort_pre_count", smp_cnt[69], 4'd2);
        n_done = 0;
        for (int k = 0; k < 70; k++) if (smp_done[k] === 1'b1) n_done++;
        chk("abort_pre_done", n_done, 0);
        reset = 1'b1;
        #1;
        chk("abort_tx_out", txo[0], 1'b1);
        chk("abort_count", cnt_a, 3'd0);
        chk("abort_busy", bsy[0], 1'b0);
        chk("abort_ready", rdy[0], 1'b0);
        chk("abort_done", dn[0], 1'b0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("abort_ready_rise", rdy[0], 1'b1);
        wq[0] = 9'h0A5;
        fr[0] = 11'b0_1101001010;
        run(0, 1, 200);
        check_stream("post_abort", 1, 10, 200, 160);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
